if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction-fetch stage of the 5-stage MIPS pipeline; the producer side of the IF/ID pipeline register. It owns the PC, issues requests to a variable-latency instruction memory, and absorbs ID-stage stalls by buffering one fetched word. It applies branch/jump redirects from ID and drives the IF/ID `IR_D_en` and `flush` inputs so that IF/ID captures either a valid instruction, a bubble, or holds.

## Interface
- WIDTH, 32, datapath/address width
- RESET_PC, 32'h0000_3000, first fetch address after reset
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hazard unit: ID must hold; IF/ID not written
- redirect  in  1  ID: taken branch/jump this cycle
- redirect_pc  in  WIDTH  target; bits [1:0] forced to 0
- imem_req  out  1  fetch request
- imem_addr  out  WIDTH  fetch address, word aligned
- imem_ack  in  1  read data valid this cycle; may be same cycle as req
- imem_rdata  in  WIDTH  instruction word
- if_pc4  out  WIDTH  PC+4 of delivered instruction, to IF/ID PC4_D_in
- if_ir  out  WIDTH  delivered instruction, to IF/ID IR_D_in
- if_en  out  1  to IF/ID IR_D_en
- if_flush  out  1  to IF/ID flush (bubble insert)

## Operation
- Registers: pc, state, hold_ir, hold_pc4, tgt. States IDLE, FETCH, HOLD, DRAIN.
- redirect is qualified by !stall; redirect with stall=1 is ignored (ID re-asserts after stall).
- Memory rule: once imem_req=1, imem_req and imem_addr stay stable until imem_ack; a request is never abandoned.
- IDLE (reset state): imem_req=0, if_en=0, if_flush=1, if_ir=0, if_pc4=pc+4. Next: FETCH unconditionally.
- FETCH: imem_req=1, imem_addr=pc, if_pc4=pc+4, if_ir=imem_rdata.
  - ack & redirect: discard data, if_en=0, pc<=redirect_pc, stay FETCH.
  - ack & stall: hold_ir<=imem_rdata, hold_pc4<=pc+4, pc<=pc+4, if_en=0, go HOLD.
  - ack, otherwise: if_en=1, pc<=pc+4, stay FETCH.
  - no ack & redirect: tgt<=redirect_pc, go DRAIN.
  - no ack, otherwise: if_en=0, stay FETCH.
- DRAIN: imem_req=1, imem_addr=pc (old address), if_en=0. Further redirect overwrites tgt (newest wins). On ack: discard data, pc<=tgt (or redirect_pc if redirect this same cycle), go FETCH.
- HOLD: imem_req=0, if_ir=hold_ir, if_pc4=hold_pc4.
  - redirect: discard buffer, pc<=redirect_pc, if_en=0, go FETCH.
  - !stall: if_en=1, go FETCH.
  - stall: if_en=0, stay HOLD.
- if_flush = 1 in IDLE; otherwise !stall & !if_en (bubble whenever ID advances without a valid instruction, including every redirect cycle). Under stall, if_en=0 and if_flush=0, so IF/ID holds.
- Arithmetic: pc+4 is modulo 2^WIDTH (0xFFFF_FFFC -> 0x0000_0000). pc[1:0] are always 0.

## Timing
- Reset values (async, while rst_n=0): state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_en=0, if_flush=1, if_ir=0, if_pc4=RESET_PC+4.
- Reset mid-request: the request is dropped immediately and imem_req=0. Memory must tolerate this.
- First imem_req is on the second rising edge after rst_n deasserts (one IDLE cycle).
- Zero-wait memory (ack same cycle): 1 instruction per cycle. Data goes combinationally to if_ir and is captured by IF/ID at the same edge.
- Redirect accepted in cycle N with ack in N: imem_addr=redirect_pc in N+1. Without ack: target fetched the cycle after the outstanding ack.
- Stall release from HOLD: buffered instruction delivered in the release cycle. Next fetch starts the cycle after.
- if_en and if_flush are never both 1.

## Test plan
- Reset, zero-wait memory returning addr as data: imem_addr 0x3000, 0x3004, 0x3008 on consecutive cycles; if_en=1 each cycle; if_pc4 0x3004, 0x3008, 0x300C.
- Stall for 3 cycles arriving with ack at 0x3004: enter HOLD, if_en=0, if_flush=0, imem_req=0. On release, if_ir=word(0x3004), if_en=1, then imem_addr=0x3008.
- Redirect to 0x4000 with ack at 0x3008: if_flush=1 that cycle, next imem_addr=0x4000, no instruction from 0x3008 delivered.
- 3-cycle-latency memory, redirect to 0x5000 in the first wait cycle, then redirect to 0x6000 in the second: imem_addr held at old address until ack, data discarded, next request 0x6000.
- pc=0xFFFF_FFFC with ack: if_pc4=0x0, next imem_addr=0x0. Redirect_pc=0x4002 yields imem_addr=0x4000.
- rst_n low during DRAIN: imem_req drops to 0 immediately; after release, IDLE for one cycle, then fetch at RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: hazard/redirect inputs, instruction memory bus and IF/ID outputs of the fetch stage.
interface if_fetch_unit_if #(parameter int WIDTH = 32);
  logic             stall;
  logic             redirect;
  logic [WIDTH-1:0] redirect_pc;
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ack;
  logic [WIDTH-1:0] imem_rdata;
  logic [WIDTH-1:0] if_pc4;
  logic [WIDTH-1:0] if_ir;
  logic             if_en;
  logic             if_flush;
  modport master (
    input  stall, redirect, redirect_pc, imem_ack, imem_rdata,
    output imem_req, imem_addr, if_pc4, if_ir, if_en, if_flush
  );
  modport slave (
    output stall, redirect, redirect_pc, imem_ack, imem_rdata,
    input  imem_req, imem_addr, if_pc4, if_ir, if_en, if_flush
  );
endinterface

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: MIPS IF stage; owns the PC, fetches from variable-latency imem,
// buffers one word across ID stalls and applies branch/jump redirects.
module if_fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_3000
) (
  input logic           clk,
  input logic           rst_n,
  if_fetch_unit_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0, FETCH = 2'd1, HOLD = 2'd2, DRAIN = 2'd3;
  logic [1:0] state, state_d;
  logic [WIDTH-1:0] pc, pc_d, pc4, tgt, tgt_d, hold_ir, hold_pc4, rpc;
  logic rd, ld_hold;
  assign pc4 = pc + WIDTH'(4);
  assign rpc = bus.redirect_pc & ~WIDTH'(3);
  assign rd = bus.redirect & ~bus.stall;
  assign bus.imem_req = state == FETCH || state == DRAIN;
  assign bus.imem_addr = pc;
  assign bus.if_ir = state == IDLE ? '0 : state == HOLD ? hold_ir : bus.imem_rdata;
  assign bus.if_pc4 = state == HOLD ? hold_pc4 : pc4;
  assign bus.if_en = ~bus.stall & ~rd & ((state == FETCH & bus.imem_ack) | state == HOLD);
  assign bus.if_flush = state == IDLE | (~bus.stall & ~bus.if_en);
  // An outstanding request is never abandoned: a redirect without ack parks in tgt until the ack.
  always_comb begin
    state_d = state;
    pc_d = pc;
    tgt_d = tgt;
    ld_hold = 1'b0;
    case (state)
      IDLE: state_d = FETCH;
      FETCH:
        if (bus.imem_ack) begin
          pc_d = rd ? rpc : pc4;
          ld_hold = ~rd & bus.stall;
          state_d = ld_hold ? HOLD : FETCH;
        end else if (rd) begin
          tgt_d = rpc;
          state_d = DRAIN;
        end
      HOLD: begin
        pc_d = rd ? rpc : pc;
        state_d = bus.stall ? HOLD : FETCH;
      end
      DRAIN: begin
        tgt_d = rd ? rpc : tgt;
        if (bus.imem_ack) begin
          pc_d = tgt_d;
          state_d = FETCH;
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      tgt <= '0;
      hold_ir <= '0;
      hold_pc4 <= '0;
    end else begin
      state <= state_d;
      pc <= pc_d;
      tgt <= tgt_d;
      if (ld_hold) begin
        hold_ir <= bus.imem_rdata;
        hold_pc4 <= pc4;
      end
    end
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed vectors against a flag-based fetch model plus literal checks;
// memory answers with its own address after a programmable wait count.
module tb_if_fetch_unit;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] lat, wcnt;
  int n_chk = 0;
  int n_fail = 0;
  if_fetch_unit_if bus();
  if_fetch_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign bus.imem_ack = bus.imem_req && wcnt >= lat;
  assign bus.imem_rdata = bus.imem_addr;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) wcnt <= 4'd0;
    else wcnt <= (bus.imem_req && !bus.imem_ack) ? wcnt + 4'd1 : 4'd0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Model: idle = post-reset bubble, held = word buffered for stalled ID, pend = redirect awaiting old ack.
  logic m_idle, m_held, m_pend;
  logic [31:0] m_pc, m_tgt, m_hir, m_hpc4, m_rpc;
  logic m_rd;
  assign m_rd = bus.redirect && !bus.stall;
  assign m_rpc = {bus.redirect_pc[31:2], 2'b00};
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_idle <= 1'b1;
      m_held <= 1'b0;
      m_pend <= 1'b0;
      m_pc <= 32'h0000_3000;
      m_tgt <= 32'h0;
      m_hir <= 32'h0;
      m_hpc4 <= 32'h0;
    end else if (m_idle) m_idle <= 1'b0;
    else if (m_held) begin
      if (m_rd) m_pc <= m_rpc;
      if (m_rd || !bus.stall) m_held <= 1'b0;
    end else if (m_pend) begin
      if (bus.imem_ack) begin
        m_pend <= 1'b0;
        m_pc <= m_rd ? m_rpc : m_tgt;
      end else if (m_rd) m_tgt <= m_rpc;
    end else if (bus.imem_ack) begin
      if (m_rd) m_pc <= m_rpc;
      else begin
        m_pc <= m_pc + 32'd4;
        if (bus.stall) begin
          m_held <= 1'b1;
          m_hir <= m_pc;
          m_hpc4 <= m_pc + 32'd4;
        end
      end
    end else if (m_rd) begin
      m_pend <= 1'b1;
      m_tgt <= m_rpc;
    end
  always @(negedge clk) begin
    logic e_en;
    e_en = !m_idle && !m_pend && !m_rd && !bus.stall && (m_held || bus.imem_ack);
    chk("req", 32'(bus.imem_req), 32'(!m_idle && !m_held));
    chk("addr", bus.imem_addr, m_pc);
    chk("en", 32'(bus.if_en), 32'(e_en));
    chk("flush", 32'(bus.if_flush), 32'(m_idle || (!bus.stall && !e_en)));
    if (m_idle || m_held || e_en) chk("ir", bus.if_ir, m_idle ? 32'h0 : m_held ? m_hir : m_pc);
    if (!m_pend) chk("pc4", bus.if_pc4, m_held ? m_hpc4 : m_pc + 32'd4);
  end
  task automatic drive(input logic s, input logic r, input logic [31:0] p, input logic [3:0] l);
    @(posedge clk);
    #1;
    bus.stall = s;
    bus.redirect = r;
    bus.redirect_pc = p;
    lat = l;
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [15:0] t_s, t_r;
    t_s = 16'b0011_0110_0001_1100;
    t_r = 16'b0100_1001_0110_0100;
    rst_n = 1'b0;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    lat = 4'd0;
    #12;
    chk("rst_req", 32'(bus.imem_req), 32'h0);
    chk("rst_addr", bus.imem_addr, 32'h3000);
    chk("rst_flush", 32'(bus.if_flush), 32'h1);
    chk("rst_en", 32'(bus.if_en), 32'h0);
    chk("rst_ir", bus.if_ir, 32'h0);
    chk("rst_pc4", bus.if_pc4, 32'h3004);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("idle_req", 32'(bus.imem_req), 32'h0);
    drive(0, 0, 0, 0);
    chk("f0_addr", bus.imem_addr, 32'h3000);
    chk("f0_en", 32'(bus.if_en), 32'h1);
    chk("f0_pc4", bus.if_pc4, 32'h3004);
    drive(1, 0, 0, 0);
    chk("st_addr", bus.imem_addr, 32'h3004);
    chk("st_en", 32'(bus.if_en), 32'h0);
    chk("st_flush", 32'(bus.if_flush), 32'h0);
    drive(1, 0, 0, 0);
    chk("hold_req", 32'(bus.imem_req), 32'h0);
    chk("hold_ir", bus.if_ir, 32'h3004);
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("rel_en", 32'(bus.if_en), 32'h1);
    chk("rel_ir", bus.if_ir, 32'h3004);
    chk("rel_pc4", bus.if_pc4, 32'h3008);
    drive(0, 1, 32'h4000, 0);
    chk("rd_addr", bus.imem_addr, 32'h3008);
    chk("rd_en", 32'(bus.if_en), 32'h0);
    chk("rd_flush", 32'(bus.if_flush), 32'h1);
    drive(0, 0, 0, 0);
    chk("tgt_addr", bus.imem_addr, 32'h4000);
    drive(0, 1, 32'h5000, 3);
    chk("w0_flush", 32'(bus.if_flush), 32'h1);
    drive(0, 1, 32'h6000, 3);
    chk("dr_req", 32'(bus.imem_req), 32'h1);
    chk("dr_addr", bus.imem_addr, 32'h4004);
    drive(0, 0, 0, 3);
    drive(0, 0, 0, 3);
    chk("dr_ack", 32'(bus.imem_ack), 32'h1);
    chk("dr_en", 32'(bus.if_en), 32'h0);
    drive(0, 0, 0, 0);
    chk("new_addr", bus.imem_addr, 32'h6000);
    chk("new_ir", bus.if_ir, 32'h6000);
    drive(0, 1, 32'hFFFF_FFFC, 0);
    drive(0, 0, 0, 0);
    chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
    chk("wrap_pc4", bus.if_pc4, 32'h0);
    drive(0, 1, 32'h4002, 0);
    chk("wrap_next", bus.imem_addr, 32'h0);
    drive(0, 0, 0, 0);
    chk("align_addr", bus.imem_addr, 32'h4000);
    drive(0, 1, 32'h7000, 3);
    drive(0, 0, 0, 3);
    chk("rdr_req", 32'(bus.imem_req), 32'h1);
    #1 rst_n = 1'b0;
    #1 chk("rdr_drop", 32'(bus.imem_req), 32'h0);
    chk("rdr_addr", bus.imem_addr, 32'h3000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    lat = 4'd0;
    #1 chk("rdr_idle", 32'(bus.imem_req), 32'h0);
    drive(0, 0, 0, 0);
    chk("rdr_fetch", bus.imem_addr, 32'h3000);
    chk("rdr_en", 32'(bus.if_en), 32'h1);
    for (int i = 0; i < 16; i++)
      drive(t_s[i], t_r[i], 32'h8000 + 32'(i) * 32'h13, 4'(i % 3));
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
